// File: rtl/booth_pkg.sv
// Shared types and widths for the radix-4 Booth partial-product generator.
package booth_pkg;

  localparam int DATA_W = 8;
  localparam int ROW_W  = DATA_W + 2;
  localparam int PP1_W  = 16;
  localparam int PP2_W  = 14;
  localparam int PP3_W  = 12;
  localparam int PP4_W  = 10;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  localparam booth_digit_t DIGIT_ZERO = '{neg: 1'b0, one: 1'b0, two: 1'b0};

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth digit encoder: {b[2k+1], b[2k], b[2k-1]} -> {neg, one, two}.
module booth_r4_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0]   i_grp,
  output booth_digit_t o_digit
);

  always_comb begin
    o_digit = DIGIT_ZERO;
    // 111 is -0 and must encode as the zero digit, so neg is masked there
    o_digit.neg = i_grp[2] & ~(i_grp[1] & i_grp[0]);
    o_digit.one = i_grp[1] ^ i_grp[0];
    o_digit.two = (i_grp[2] & ~i_grp[1] & ~i_grp[0]) | (~i_grp[2] & i_grp[1] & i_grp[0]);
  end

endmodule

// File: rtl/booth_radix4_pp_gen.sv
// Two-stage radix-4 Booth encoder and partial-product row generator for an 8x8 signed multiply.
module booth_radix4_pp_gen #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       pp1,
  output logic [13:0]       pp2,
  output logic [11:0]       pp3,
  output logic [9:0]        pp4,
  output logic [CNT_W-1:0]  prod_count
);

  import booth_pkg::booth_digit_t;
  import booth_pkg::ROW_W;
  import booth_pkg::PP1_W;
  import booth_pkg::PP2_W;
  import booth_pkg::PP3_W;
  import booth_pkg::PP4_W;

  function automatic logic signed [ROW_W-1:0] booth_row(
    input logic signed [DATA_W-1:0] a,
    input booth_digit_t             d
  );
    logic signed [ROW_W-1:0] mag;
    mag = '0;
    if (d.two)      mag = {{(ROW_W-DATA_W-1){a[DATA_W-1]}}, a, 1'b0};
    else if (d.one) mag = {{(ROW_W-DATA_W){a[DATA_W-1]}}, a};
    return d.neg ? -mag : mag;
  endfunction

  logic                     w_s1_adv;
  logic                     w_s2_adv;
  logic [DATA_W:0]          w_b_ext;
  booth_digit_t             w_dig [4];
  logic signed [ROW_W-1:0]  w_row [4];

  logic                     r_vld_p1;
  logic signed [DATA_W-1:0] r_a_p1;
  booth_digit_t             r_dig_p1 [4];

  logic                     r_vld_p2;
  logic [PP1_W-1:0]         r_pp1_p2;
  logic [PP2_W-1:0]         r_pp2_p2;
  logic [PP3_W-1:0]         r_pp3_p2;
  logic [PP4_W-1:0]         r_pp4_p2;
  logic [CNT_W-1:0]         r_cnt;

  assign w_s2_adv = ~r_vld_p2 | out_ready;
  assign w_s1_adv = ~r_vld_p1 | w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_b_ext  = {in_b, 1'b0};

  for (genvar k = 0; k < 4; k++) begin : g_enc
    booth_r4_digit_enc u_enc (
      .i_grp  (w_b_ext[2*k+2 -: 3]),
      .o_digit(w_dig[k])
    );
  end

  // Stage 1: register multiplicand and encoded digits
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else if (w_s1_adv) r_vld_p1 <= in_valid;
    if (in_valid && w_s1_adv) begin
      r_a_p1 <= in_a;
      for (int k = 0; k < 4; k++) r_dig_p1[k] <= w_dig[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) w_row[k] = booth_row(r_a_p1, r_dig_p1[k]);
  end

  // Stage 2: sign-extended partial-product rows
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_pp1_p2 <= '0;
      r_pp2_p2 <= '0;
      r_pp3_p2 <= '0;
      r_pp4_p2 <= '0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_pp1_p2 <= {{(PP1_W-ROW_W){w_row[0][ROW_W-1]}}, w_row[0]};
        r_pp2_p2 <= {{(PP2_W-ROW_W){w_row[1][ROW_W-1]}}, w_row[1]};
        r_pp3_p2 <= {{(PP3_W-ROW_W){w_row[2][ROW_W-1]}}, w_row[2]};
        r_pp4_p2 <= w_row[3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (r_vld_p2 && out_ready) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign out_valid  = r_vld_p2;
  assign pp1        = r_pp1_p2;
  assign pp2        = r_pp2_p2;
  assign pp3        = r_pp3_p2;
  assign pp4        = r_pp4_p2;
  assign prod_count = r_cnt;

endmodule
